// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle controller
//
// Purpose: opcode/func constants, ALUctr constants, the FSM state encoding
// and the width derivation for the MEM wait counter.
// Ports: none (package).
package ctrl_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;
  localparam logic [2:0] OP_ORI  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  // Counter only has to hold 0..max_wait-1; keep at least one bit.
  function automatic int wait_cnt_w(input int max_wait);
    return (max_wait <= 1) ? 1 : $clog2(max_wait);
  endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// rtl/ctrl_alu_decode.sv - combinational op/func to ALU control decode
//
// Purpose: maps an opcode/func pair to ALUctr, ExtOp, ALUSrc and flags
// illegal encodings.
// Ports: op, func (in, 3b); alu_ctr (out, 3b); ext_op, alu_src, illegal (out, 1b).
module ctrl_alu_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] func,
  output logic [2:0] alu_ctr,
  output logic       ext_op,
  output logic       alu_src,
  output logic       illegal
);

  always_comb begin
    alu_ctr = ALU_ADD;
    ext_op  = 1'b0;
    alu_src = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        case (func)
          FN_ADD:  alu_ctr = ALU_ADD;
          FN_SUB:  alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_SLT:  alu_ctr = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        alu_ctr = ALU_ADD;
      end
      OP_ORI: begin
        alu_src = 1'b1;
        alu_ctr = ALU_OR;
      end
      OP_BEQ:  alu_ctr = ALU_SUB;
      OP_J:    alu_ctr = ALU_ADD;
      OP_ILL:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
//
// Purpose: sequences each DataPath instruction, drives DataPath control,
// IR/PC write enables, handshakes data memory and traps on errors.
// Ports: clk, rst (async active-low), op/func (IR fields), mem_ready;
//        outputs Branch, Jump, RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp,
//        ALUctr[2:0], IRWr, PCWr, trap, state[2:0];
//        instr_cnt[CNT_W-1:0] only when MULTICYCLE_CTRL_INSTR_CNT_EN is defined.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [2:0]       func,
  input  logic             mem_ready,
  output logic             Branch,
  output logic             Jump,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWr,
  output logic             MemWr,
  output logic             ExtOp,
  output logic [2:0]       ALUctr,
  output logic             IRWr,
  output logic             PCWr,
  output logic             trap,
  output logic [2:0]       state
`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int WAIT_W = wait_cnt_w(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d, func_q, func_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [2:0] dec_op, dec_func, dec_alu_ctr;
  logic       dec_ext_op, dec_alu_src, dec_illegal;

  // DECODE judges the live IR fields; later states use the latched copy.
  assign dec_op   = (state_q == ST_DECODE) ? op   : op_q;
  assign dec_func = (state_q == ST_DECODE) ? func : func_q;

  ctrl_alu_decode u_alu_decode (
    .op      (dec_op),
    .func    (dec_func),
    .alu_ctr (dec_alu_ctr),
    .ext_op  (dec_ext_op),
    .alu_src (dec_alu_src),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    wait_d  = wait_q;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d   = op;
        func_d = func;
        if (dec_illegal)     state_d = ST_TRAP;
        else if (op == OP_J) state_d = ST_FETCH;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        wait_d = '0;
        if (op_q == OP_BEQ)                         state_d = ST_FETCH;
        else if (op_q == OP_LW || op_q == OP_SW)    state_d = ST_MEM;
        else                                        state_d = ST_WB;
      end
      ST_MEM: begin
        // mem_ready takes priority over an expiring wait counter.
        if (mem_ready)               state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        else if (wait_q == WAIT_LAST) state_d = ST_TRAP;
        else                         wait_d  = wait_q + WAIT_W'(1);
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are pure decode of state and latched IR; forced low in reset.
  always_comb begin
    Branch   = 1'b0;
    Jump     = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    ExtOp    = 1'b0;
    ALUctr   = 3'b000;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    trap     = 1'b0;
    state    = 3'b000;
    if (rst) begin
      state = state_q;
      case (state_q)
        ST_FETCH: IRWr = 1'b1;
        ST_DECODE: begin
          if (!dec_illegal && op == OP_J) begin
            Jump = 1'b1;
            PCWr = 1'b1;
          end
        end
        ST_EXEC, ST_MEM, ST_WB: begin
          ALUctr = dec_alu_ctr;
          ALUSrc = dec_alu_src;
          ExtOp  = dec_ext_op;
          if (state_q == ST_EXEC && op_q == OP_BEQ) begin
            Branch = 1'b1;
            PCWr   = 1'b1;
          end
          if (state_q == ST_MEM && op_q == OP_SW) begin
            MemWr = 1'b1;
            PCWr  = mem_ready;
          end
          if (state_q == ST_WB) begin
            RegWr    = 1'b1;
            PCWr     = 1'b1;
            RegDst   = (op_q == OP_R);
            MemtoReg = (op_q == OP_LW);
          end
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (PCWr) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
